// File: rtl/cnn_stream_pkg.sv
// Shared types and default geometry for the CNN crop streamer.
package cnn_stream_pkg;
  localparam int FP_TOTAL = 8;
  localparam int OUT_ROWS = 5;
  localparam int OUT_COLS = 5;
  localparam int NPIX     = OUT_ROWS * OUT_COLS;
  localparam int N_OUT    = 5;

  typedef logic [FP_TOTAL-1:0]      pix_t;
  typedef logic [$clog2(NPIX)-1:0]  idx_t;

  typedef enum logic [1:0] {LOAD, STREAM, WAIT, HOLD} state_t;
endpackage

// File: rtl/cnn_pix_buffer.sv
// Crop storage: one register per pixel, synchronous write, combinational read.
module cnn_pix_buffer #(
  parameter int W     = 8,
  parameter int DEPTH = 25,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [DEPTH-1:0][W-1:0] mem;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    // Each entry captures the incoming pixel when its address is written.
    always_ff @(posedge clk) begin
      if (we && waddr == AW'(i)) mem[i] <= wdata;
    end
  end

  // Out-of-range addresses (one past the last pixel) read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++)
      if (raddr == AW'(i)) rdata = mem[i];
  end
endmodule

// File: rtl/cnn_crop_streamer.sv
// Buffers one crop, runs the ap_ctrl_hs start handshake, streams the crop
// into the CNN and holds the packed prediction for a downstream consumer.
module cnn_crop_streamer #(
  parameter int FP_TOTAL = cnn_stream_pkg::FP_TOTAL,
  parameter int OUT_ROWS = cnn_stream_pkg::OUT_ROWS,
  parameter int OUT_COLS = cnn_stream_pkg::OUT_COLS,
  parameter int N_OUT    = cnn_stream_pkg::N_OUT
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [FP_TOTAL-1:0]       s_pix_data,
  input  logic                      s_pix_valid,
  output logic                      s_pix_ready,
  output logic                      cnn_ap_start,
  input  logic                      cnn_ap_ready,
  output logic [FP_TOTAL-1:0]       input_1_TDATA,
  output logic                      input_1_TVALID,
  input  logic                      input_1_TREADY,
  input  logic [N_OUT*FP_TOTAL-1:0] layer5_out_TDATA,
  input  logic                      layer5_out_TVALID,
  output logic                      layer5_out_TREADY,
  output logic [N_OUT*FP_TOTAL-1:0] pred_data,
  output logic                      pred_valid,
  input  logic                      pred_ready,
  output logic [15:0]               frame_cnt,
  output logic                      busy
);
  import cnn_stream_pkg::*;

  localparam int NP = OUT_ROWS * OUT_COLS;
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;

  state_t              state, state_nxt;
  logic [IW-1:0]       wr_idx, rd_idx, raddr;
  logic [FP_TOTAL-1:0] rdata, preload;
  logic                started;
  logic                pix_hs, in_hs, l5_hs, pred_hs, wr_last, rd_last;

  assign pix_hs  = s_pix_valid & s_pix_ready;
  assign in_hs   = input_1_TVALID & input_1_TREADY;
  assign l5_hs   = layer5_out_TVALID & layer5_out_TREADY;
  assign pred_hs = pred_valid & pred_ready;
  assign wr_last = pix_hs && (wr_idx == IW'(NP - 1));
  assign rd_last = in_hs && (rd_idx == IW'(NP - 1));

  // During LOAD the read port looks at pixel 0 so it can be preloaded on the
  // last write; while streaming it looks one ahead of the pixel on the bus.
  assign raddr   = (state == LOAD) ? '0 : rd_idx + 1'b1;
  // A one-pixel crop has not landed in the buffer yet when it must preload.
  assign preload = (NP == 1) ? s_pix_data : rdata;

  cnn_pix_buffer #(.W(FP_TOTAL), .DEPTH(NP), .AW(IW)) u_buf (
    .clk   (ap_clk),
    .we    (pix_hs),
    .waddr (wr_idx),
    .wdata (s_pix_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= LOAD;
    else           state <= state_nxt;
  end

  // Next-state decode: one crop in, one crop out, one prediction, release.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:   if (wr_last) state_nxt = STREAM;
      STREAM: if (rd_last) state_nxt = WAIT;
      WAIT:   if (l5_hs)   state_nxt = HOLD;
      HOLD:   if (pred_hs) state_nxt = LOAD;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    s_pix_ready       = (state == LOAD);
    layer5_out_TREADY = (state == WAIT);
    busy              = (state != LOAD);
  end

  // Write/read indices; both rewind when the prediction is released.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else if (pred_hs) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (pix_hs) wr_idx <= wr_idx + 1'b1;
      if (in_hs)  rd_idx <= rd_idx + 1'b1;
    end
  end

  // input_1 stream register: preload on the last write, advance per transfer.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      input_1_TVALID <= 1'b0;
      input_1_TDATA  <= '0;
    end else if (wr_last) begin
      input_1_TVALID <= 1'b1;
      input_1_TDATA  <= preload;
    end else if (in_hs) begin
      if (rd_last) input_1_TVALID <= 1'b0;
      else         input_1_TDATA  <= rdata;
    end
  end

  // ap_start rises with the stream and drops once ap_ready has been seen.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnn_ap_start <= 1'b0;
      started      <= 1'b0;
    end else if (pred_hs) begin
      cnn_ap_start <= 1'b0;
      started      <= 1'b0;
    end else if (wr_last) begin
      cnn_ap_start <= ~started;
    end else if (cnn_ap_start && cnn_ap_ready) begin
      cnn_ap_start <= 1'b0;
      started      <= 1'b1;
    end
  end

  // Prediction capture and hold until the consumer takes it.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pred_valid <= 1'b0;
      pred_data  <= '0;
    end else if (l5_hs) begin
      pred_valid <= 1'b1;
      pred_data  <= layer5_out_TDATA;
    end else if (pred_hs) begin
      pred_valid <= 1'b0;
    end
  end

  // Completed-prediction counter, free-running wrap.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)    frame_cnt <= '0;
    else if (pred_hs) frame_cnt <= frame_cnt + 16'd1;
  end
endmodule

// File: tb/tb_cnn_crop_streamer.sv
// Directed bench for cnn_crop_streamer: table of whole-frame scenarios plus
// hand-written reset and counter-wrap sequences.
module tb_cnn_crop_streamer;
  localparam int NPIX = 25;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [7:0]  s_pix_data = '0;
  logic        s_pix_valid = 1'b0;
  logic        s_pix_ready;
  logic        cnn_ap_start;
  logic        cnn_ap_ready = 1'b0;
  logic [7:0]  input_1_TDATA;
  logic        input_1_TVALID;
  logic        input_1_TREADY = 1'b0;
  logic [39:0] layer5_out_TDATA = '0;
  logic        layer5_out_TVALID = 1'b0;
  logic        layer5_out_TREADY;
  logic [39:0] pred_data;
  logic        pred_valid;
  logic        pred_ready = 1'b0;
  logic [15:0] frame_cnt;
  logic        busy;

  cnn_crop_streamer dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_pix_data(s_pix_data), .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready),
    .cnn_ap_start(cnn_ap_start), .cnn_ap_ready(cnn_ap_ready),
    .input_1_TDATA(input_1_TDATA), .input_1_TVALID(input_1_TVALID),
    .input_1_TREADY(input_1_TREADY),
    .layer5_out_TDATA(layer5_out_TDATA), .layer5_out_TVALID(layer5_out_TVALID),
    .layer5_out_TREADY(layer5_out_TREADY),
    .pred_data(pred_data), .pred_valid(pred_valid), .pred_ready(pred_ready),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  int   checks = 0;
  int   errors = 0;
  int   apr_lat, apr_cyc;
  logic exp_start;

  typedef struct {
    logic [7:0]  base;
    int          bp;
    int          apr;
    int          hc;
    logic [39:0] res;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drives ap_ready per the scenario latency and checks ap_start against a
  // flag that drops one cycle after ap_ready meets a high ap_start.
  task automatic step_apr();
    chk("ap_start", {63'd0, cnn_ap_start}, {63'd0, exp_start});
    cnn_ap_ready = (apr_cyc >= apr_lat);
    if (exp_start && cnn_ap_ready) exp_start = 1'b0;
    apr_cyc++;
  endtask

  task automatic do_load(input logic [7:0] base);
    int k = 0;
    int g = 0;
    while (k < NPIX && g < 100) begin
      @(negedge ap_clk); g++;
      s_pix_valid = 1'b1;
      s_pix_data  = base + 8'(k);
      if (s_pix_ready) k++;
    end
    chk("load_cnt", 64'(k), 64'(NPIX));
  endtask

  task automatic do_stream(input int bp, input int stop, input logic [7:0] base, output int n);
    logic [7:0] prev_td = '0;
    logic       prev_stall = 1'b0;
    int         c = 0;
    n = 0;
    while (n < stop && c < 300) begin
      @(negedge ap_clk); c++;
      s_pix_valid = 1'b0;
      step_apr();
      if (c == 1) begin
        chk("tvalid_first", {63'd0, input_1_TVALID}, 64'd1);
        chk("spix_rdy_stream", {63'd0, s_pix_ready}, 64'd0);
        chk("busy_stream", {63'd0, busy}, 64'd1);
      end
      if (prev_stall) chk("tdata_stable", {56'd0, input_1_TDATA}, {56'd0, prev_td});
      input_1_TREADY = (bp == 0) ? 1'b1 : (c % 4 == 1 || c % 4 == 0);
      if (input_1_TVALID && input_1_TREADY) begin
        chk("tdata", {56'd0, input_1_TDATA}, {56'd0, base + 8'(n)});
        n++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = input_1_TVALID;
        prev_td    = input_1_TDATA;
      end
    end
    if (bp == 0) chk("no_gaps", 64'(c), 64'(stop));
  endtask

  task automatic do_wait(input logic [39:0] res);
    int   c = 0;
    logic done = 1'b0;
    while (!done && c < 200) begin
      @(negedge ap_clk); c++;
      step_apr();
      if (c == 1) begin
        chk("tvalid_wait", {63'd0, input_1_TVALID}, 64'd0);
        chk("l5_tready", {63'd0, layer5_out_TREADY}, 64'd1);
      end
      layer5_out_TVALID = ~exp_start;
      layer5_out_TDATA  = res;
      if (layer5_out_TVALID && layer5_out_TREADY) done = 1'b1;
    end
    chk("l5_handshake", {63'd0, done}, 64'd1);
  endtask

  task automatic do_hold(input int hc, input logic [39:0] res, input logic [15:0] cnt);
    for (int i = 0; i <= hc; i++) begin
      @(negedge ap_clk);
      layer5_out_TVALID = 1'b0;
      layer5_out_TDATA  = ~res;
      cnn_ap_ready      = 1'b0;
      chk("pred_valid", {63'd0, pred_valid}, 64'd1);
      chk("pred_data", {24'd0, pred_data}, {24'd0, res});
      chk("spix_rdy_hold", {63'd0, s_pix_ready}, 64'd0);
      if (i == 0) chk("start_hold", {63'd0, cnn_ap_start}, 64'd0);
      pred_ready = (i == hc);
    end
    @(negedge ap_clk);
    pred_ready = 1'b0;
    chk("spix_rdy_load", {63'd0, s_pix_ready}, 64'd1);
    chk("pred_valid_clr", {63'd0, pred_valid}, 64'd0);
    chk("busy_load", {63'd0, busy}, 64'd0);
    chk("frame_cnt", {48'd0, frame_cnt}, {48'd0, cnt});
  endtask

  task automatic run_frame(input logic [7:0] base, input int bp, input int al, input int hc,
                           input logic [39:0] res, input logic [15:0] cnt);
    int n;
    apr_lat = al; apr_cyc = 0; exp_start = 1'b1;
    do_load(base);
    do_stream(bp, NPIX, base, n);
    chk("xfers", 64'(n), 64'(NPIX));
    do_wait(res);
    do_hold(hc, res, cnt);
  endtask

  task automatic chk_reset_vals();
    chk("rst_tvalid", {63'd0, input_1_TVALID}, 64'd0);
    chk("rst_tdata", {56'd0, input_1_TDATA}, 64'd0);
    chk("rst_start", {63'd0, cnn_ap_start}, 64'd0);
    chk("rst_pred_valid", {63'd0, pred_valid}, 64'd0);
    chk("rst_pred_data", {24'd0, pred_data}, 64'd0);
    chk("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_l5_tready", {63'd0, layer5_out_TREADY}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    // base, backpressure, ap_ready latency, pred_ready hold, prediction, count
    vecs[0] = '{8'h00, 0, 0,  0, 40'h0403020100, 16'd1};
    vecs[1] = '{8'h40, 1, 3,  2, 40'h1122334455, 16'd2};
    vecs[2] = '{8'h80, 0, 40, 0, 40'hA5A5A5A5A5, 16'd3};
    vecs[3] = '{8'hE0, 0, 1, 10, 40'hFFEEDDCCBB, 16'd4};

    repeat (3) @(negedge ap_clk);
    chk_reset_vals();
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("spix_rdy_after_rst", {63'd0, s_pix_ready}, 64'd1);

    for (int i = 0; i < 4; i++)
      run_frame(vecs[i].base, vecs[i].bp, vecs[i].apr, vecs[i].hc, vecs[i].res, vecs[i].cnt);

    // Reset right after the 12th transfer of a frame.
    apr_lat = 0; apr_cyc = 0; exp_start = 1'b1;
    do_load(8'h10);
    do_stream(0, 12, 8'h10, n);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b0;
    #1 chk_reset_vals();
    @(negedge ap_clk);
    ap_rst_n = 1'b1; cnn_ap_ready = 1'b0; input_1_TREADY = 1'b0;
    run_frame(8'h30, 0, 2, 1, 40'h0102030405, 16'd1);

    // Counter wrap from 0xFFFF.
    @(negedge ap_clk);
    force dut.frame_cnt = 16'hFFFF;
    #1 release dut.frame_cnt;
    run_frame(8'h50, 1, 5, 0, 40'h00000000AA, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cnn_crop_streamer.md
# cnn_crop_streamer

Transmit-side wrapper for the `myproject` HLS CNN. It buffers one normalized crop of `OUT_ROWS*OUT_COLS` Mono8 pixels arriving from the crop/normalize stage. It then runs the `ap_ctrl_hs` start handshake, streams the crop into `input_1` over AXI-Stream, and captures the packed `layer5_out` prediction for a downstream consumer. This is the synthesizable counterpart of the pixel driver and result collector the CNN benchmark bench provides in simulation.

## Interface
Parameters:
- `FP_TOTAL`, 8: pixel and output-element width (fixed-point, `FP_INT`=0).
- `OUT_ROWS`, 5: crop rows.
- `OUT_COLS`, 5: crop columns.
- `N_OUT`, 5: CNN output elements per prediction.

Ports:
- `ap_clk`  in  1  — sole clock.
- `ap_rst_n`  in  1  — asynchronous, active-low reset.
- `s_pix_data`  in  `FP_TOTAL`  — crop pixel, row-major.
- `s_pix_valid`  in  1  — pixel valid.
- `s_pix_ready`  out  1  — pixel accepted when high together with `s_pix_valid`.
- `cnn_ap_start`  out  1  — drives `myproject.ap_start`.
- `cnn_ap_ready`  in  1  — from `myproject.ap_ready`.
- `input_1_TDATA`  out  `FP_TOTAL`  — pixel to the CNN.
- `input_1_TVALID`  out  1  — CNN input valid.
- `input_1_TREADY`  in  1  — CNN input ready.
- `layer5_out_TDATA`  in  `N_OUT*FP_TOTAL`  — packed prediction; element 0 is in `[7:0]`.
- `layer5_out_TVALID`  in  1  — prediction valid.
- `layer5_out_TREADY`  out  1  — prediction ready.
- `pred_data`  out  `N_OUT*FP_TOTAL`  — captured prediction, same packing as `layer5_out_TDATA`.
- `pred_valid`  out  1  — prediction available.
- `pred_ready`  in  1  — consumer accepts the prediction.
- `frame_cnt`  out  16  — count of completed predictions; wraps.
- `busy`  out  1  — high in every state except LOAD.

## Operation
- `NPIX = OUT_ROWS*OUT_COLS` (25). The block holds a single buffer, so there is no overlap between crops.
- **LOAD**
  - `s_pix_ready`=1.
  - Each pixel handshake writes `buf[wr_idx]` and increments `wr_idx`.
  - The handshake at `wr_idx==NPIX-1` moves the FSM to STREAM and preloads `input_1_TDATA`=`buf[0]` (bypass the value being written if `NPIX==1`).
- **STREAM**
  - `input_1_TVALID`=1.
  - `cnn_ap_start`=1 until `cnn_ap_ready` is sampled high, then 0 for the rest of the frame (sticky `started` flag).
  - On a TVALID&TREADY handshake: `rd_idx++` and `TDATA` loads `buf[rd_idx+1]`.
  - The handshake at `rd_idx==NPIX-1` moves the FSM to WAIT and drops TVALID.
  - When TREADY is low, TDATA and TVALID hold stable.
- **WAIT**
  - `layer5_out_TREADY`=1, and only in this state.
  - If `cnn_ap_ready` has not yet been seen, `cnn_ap_start` stays high.
  - On a `layer5_out` handshake, `pred_data` captures TDATA and the FSM moves to HOLD.
- **HOLD**
  - `pred_valid`=1.
  - On a `pred_ready` handshake: `frame_cnt++` (16-bit wrap, 0xFFFF→0), clear `wr_idx`, `rd_idx` and `started`, and return to LOAD.
- Pixels offered outside LOAD are not accepted (`s_pix_ready`=0).
- `ap_done` is not used; completion is defined by the `layer5_out` handshake.

## Timing
- Reset (asynchronous): state=LOAD, all indices 0, `frame_cnt`=0, `pred_data`=0, `input_1_TDATA`=0, and every valid, ready, start and busy output 0 except `s_pix_ready`, which is 1 once reset is released.
- Timing with all readies held high:
  - Last pixel accepted at cycle t.
  - Cycle t+1: STREAM, `cnn_ap_start`=1, TVALID=1, TDATA=`buf[0]`.
  - Pixel k transfers at t+1+k; the last transfers at t+NPIX.
  - WAIT from t+NPIX+1.
  - `layer5_out` handshake at cycle u gives `pred_valid`=1 at u+1.
  - `pred_ready` high at cycle v gives LOAD with `s_pix_ready`=1 at v+1.
- All outputs are registered except `s_pix_ready`, `layer5_out_TREADY` and `busy`, which decode directly from the state register.
- `cnn_ap_ready` may arrive in the same cycle `cnn_ap_start` rises. `cnn_ap_start` is then high for exactly 1 cycle.
- A reset asserted mid-frame discards the buffered crop and any pending prediction. `frame_cnt` is not incremented.

## Structure
- Package `cnn_stream_pkg`:
  - localparams `FP_TOTAL`, `OUT_ROWS`, `OUT_COLS`, `NPIX`, `N_OUT`;
  - `typedef logic [FP_TOTAL-1:0] pix_t`;
  - `typedef enum logic [1:0] {LOAD, STREAM, WAIT, HOLD} state_t`;
  - index type sized `$clog2(NPIX)`.
- One sub-module, `cnn_pix_buffer`: an `NPIX×FP_TOTAL` register array with one synchronous write port and one combinational read port.

## Test plan
- **Basic frame:** feed pixels 0x00..0x18; `input_1_TREADY`=1; model returns 0x0403020100 → `input_1` carries 0x00..0x18 in order with no gaps; `pred_data`=0x0403020100; `frame_cnt`=1.
- **Input backpressure:** toggle `input_1_TREADY` 1-0-0-1 → TDATA stable while stalled; exactly 25 transfers, none duplicated.
- **Late ap_ready:** hold `cnn_ap_ready` low for 40 cycles → `cnn_ap_start` stays high through WAIT and falls the cycle after `cnn_ap_ready`.
- **Output hold:** `pred_ready`=0 for 10 cycles → `pred_valid` and `pred_data` stable, `s_pix_ready`=0; `pred_ready`=1 → LOAD the next cycle.
- **Mid-stream reset:** assert `ap_rst_n`=0 after the 12th transfer → all outputs reach reset values immediately; the next full crop yields correct data and `frame_cnt`=1.
- **Counter wrap:** preset `frame_cnt`=0xFFFF via force, then complete one frame → `frame_cnt`=0x0000.
